// File: rtl/alu_op_sequencer.sv
// Instruction-level controller for the accumulator ALU.
// It accepts one instruction at a time, issues any memory reads it needs, then strobes the ALU enables.
module alu_op_sequencer #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid,
  output logic          ins_ready,
  input  logic [2:0]    ins_op,
  input  logic [1:0]    ins_src,
  input  logic [DW-1:0] ins_arg,
  input  logic          ins_upd_cy,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    data_src,
  output logic [2:0]    op,
  output logic [DW-1:0] immediate,
  output logic [RW-1:0] reg_sel,
  output logic          ce_a,
  output logic          ce_cy,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, PTR, LDPTR, RD, EXEC} state_t;
  typedef enum logic [1:0] {SRC_MEM_ADDR, SRC_IMMEDIATE, SRC_INDIRECT, SRC_REG} data_src_t;

  state_t          state_q, state_d;
  data_src_t       src_q, src_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   arg_q, arg_d;
  logic            upd_cy_q, upd_cy_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            unused_rdata_bits;

  // The pointer only uses the low AW bits of the read data.
  assign unused_rdata_bits = ^mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      src_q    <= SRC_MEM_ADDR;
      op_q     <= '0;
      arg_q    <= '0;
      upd_cy_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      upd_cy_q <= upd_cy_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    op_d     = op_q;
    arg_d    = arg_q;
    upd_cy_d = upd_cy_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (ins_valid) begin
          src_d    = data_src_t'(ins_src);
          op_d     = ins_op;
          arg_d    = ins_arg;
          upd_cy_d = ins_upd_cy;
          addr_d   = ins_arg[AW-1:0];
          case (data_src_t'(ins_src))
            SRC_MEM_ADDR: state_d = RD;
            SRC_INDIRECT: state_d = PTR;
            default:      state_d = EXEC;
          endcase
        end
      end
      PTR:   state_d = LDPTR;
      // Pointer read data arrives the cycle after the PTR strobe.
      LDPTR: begin
        addr_d  = mem_rdata[AW-1:0];
        state_d = RD;
      end
      RD:    state_d = EXEC;
      EXEC:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ins_ready = rst && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == EXEC);
  assign ce_a      = (state_q == EXEC) && (op_q != 3'd0);
  assign ce_cy     = ce_a && upd_cy_q;
  assign mem_rd    = (state_q == PTR) || (state_q == RD);
  assign mem_addr  = mem_rd ? addr_q : '0;
  assign data_src  = src_q;
  assign op        = op_q;
  assign immediate = arg_q;
  assign reg_sel   = arg_q[RW-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table for single instructions,
// plus hand sequences for reset behaviour and back-to-back issue.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ins_valid;
  logic       ins_ready;
  logic [2:0] ins_op;
  logic [1:0] ins_src;
  logic [7:0] ins_arg;
  logic       ins_upd_cy;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [1:0] data_src;
  logic [2:0] op;
  logic [7:0] immediate;
  logic [2:0] reg_sel;
  logic       ce_a, ce_cy, busy, done;

  logic [7:0] mem [256];
  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [2:0] op;
    logic [1:0] src;
    logic [7:0] arg;
    logic       upd;
    int         lat;
    logic       ceA;
    logic       ceCy;
    int         reads;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       chkData;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [7];

  alu_op_sequencer #(.DW(8), .AW(8), .RW(3)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_op(ins_op), .ins_src(ins_src), .ins_arg(ins_arg), .ins_upd_cy(ins_upd_cy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data_src(data_src), .op(op), .immediate(immediate), .reg_sel(reg_sel),
    .ce_a(ce_a), .ce_cy(ce_cy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},    32'(ins_ready), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy),      32'd0);
    checkOutput({tag, "_done"},     32'(done),      32'd0);
    checkOutput({tag, "_ce_a"},     32'(ce_a),      32'd0);
    checkOutput({tag, "_ce_cy"},    32'(ce_cy),     32'd0);
    checkOutput({tag, "_mem_rd"},   32'(mem_rd),    32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr),  32'd0);
    checkOutput({tag, "_data_src"}, 32'(data_src),  32'd0);
    checkOutput({tag, "_op"},       32'(op),        32'd0);
    checkOutput({tag, "_imm"},      32'(immediate), 32'd0);
    checkOutput({tag, "_reg_sel"},  32'(reg_sel),   32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int reads = 0;
    int ceCount = 0;
    int execAt = 0;
    logic [7:0] addrs [2];
    logic [2:0] expSel;
    addrs[0] = 8'h00;
    addrs[1] = 8'h00;
    expSel = v.arg[2:0];
    @(negedge clk);
    checkOutput("ready_before", 32'(ins_ready), 32'd1);
    ins_valid  = 1'b1;
    ins_op     = v.op;
    ins_src    = v.src;
    ins_arg    = v.arg;
    ins_upd_cy = v.upd;
    @(posedge clk);
    for (int k = 1; k <= 8 && execAt == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ins_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
      end
      if (mem_rd) begin
        if (reads < 2) addrs[reads] = mem_addr;
        reads++;
      end
      if (ce_a) ceCount++;
      if (done) begin
        execAt = k;
        checkOutput("exec_data_src", 32'(data_src),  32'(v.src));
        checkOutput("exec_op",       32'(op),        32'(v.op));
        checkOutput("exec_imm",      32'(immediate), 32'(v.arg));
        checkOutput("exec_reg_sel",  32'(reg_sel),   32'(expSel));
        checkOutput("exec_ce_cy",    32'(ce_cy),     32'(v.ceCy));
        checkOutput("exec_mem_addr", 32'(mem_addr),  32'd0);
        if (v.chkData) checkOutput("exec_mem_rdata", 32'(mem_rdata), 32'(v.rdata));
      end
    end
    checkOutput("exec_latency", 32'(execAt),  32'(v.lat));
    checkOutput("ce_a_pulses",  32'(ceCount), 32'(v.ceA));
    checkOutput("read_count",   32'(reads),   32'(v.reads));
    if (v.reads >= 1) checkOutput("read_addr0", 32'(addrs[0]), 32'(v.a0));
    if (v.reads >= 2) checkOutput("read_addr1", 32'(addrs[1]), 32'(v.a1));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done),      32'd0);
    checkOutput("ready_after",    32'(ins_ready), 32'd1);
  endtask

  initial begin
    int doneCount;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h40] = 8'h5A;
    mem[8'h10] = 8'h80;
    mem[8'h80] = 8'hA5;
    mem[8'h20] = 8'h40;

    //          op    src   arg    upd  lat ceA ceCy rd  a0     a1     chk  rdata
    vecs[0] = '{3'd1, 2'd1, 8'h3C, 1'b1, 1, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{3'd2, 2'd0, 8'h40, 1'b1, 2, 1'b1, 1'b1, 1, 8'h40, 8'h00, 1'b1, 8'h5A};
    vecs[2] = '{3'd3, 2'd2, 8'h10, 1'b1, 4, 1'b1, 1'b1, 2, 8'h10, 8'h80, 1'b1, 8'hA5};
    vecs[3] = '{3'd0, 2'd3, 8'h03, 1'b1, 1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{3'd5, 2'd1, 8'h77, 1'b0, 1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{3'd7, 2'd3, 8'hFD, 1'b1, 1, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{3'd4, 2'd2, 8'h20, 1'b0, 4, 1'b1, 1'b0, 2, 8'h20, 8'h40, 1'b1, 8'h5A};

    rst = 1'b0;
    ins_valid = 1'b0;
    ins_op = 3'd0;
    ins_src = 2'd0;
    ins_arg = 8'h00;
    ins_upd_cy = 1'b0;
    #12;
    checkResetValues("por");
    rst = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset lands in LDPTR of an indirect instruction; it must vanish without strobes.
    @(negedge clk);
    ins_valid = 1'b1;
    ins_op = 3'd3;
    ins_src = 2'd2;
    ins_arg = 8'h10;
    ins_upd_cy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    checkOutput("mid_ptr_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetValues("mid");
    @(negedge clk);
    checkResetValues("mid_hold");
    #2;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready",  32'(ins_ready), 32'd1);
    checkOutput("post_rst_mem_rd", 32'(mem_rd),    32'd0);
    checkOutput("post_rst_ce_a",   32'(ce_a),      32'd0);
    checkOutput("post_rst_done",   32'(done),      32'd0);

    // Back-to-back immediates with ins_valid held: one accept every two cycles.
    ins_valid = 1'b1;
    ins_op = 3'd1;
    ins_src = 2'd1;
    ins_arg = 8'h3C;
    ins_upd_cy = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) doneCount++;
      checkOutput("stream_done",  32'(done),      (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("stream_ready", 32'(ins_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        checkOutput("stream_imm",  32'(immediate), 32'h3C);
        checkOutput("stream_ce_a", 32'(ce_a),      32'd1);
      end
    end
    ins_valid = 1'b0;
    checkOutput("stream_done_count", 32'(doneCount), 32'd4);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Instruction-level controller for `alu_acc_flags`. It accepts one ALU instruction at a time through a valid/ready handshake and drives the ALU's `data_src`, `op`, `immediate`, `reg_sel`, `ce_a` and `ce_cy`. For memory and indirect sources it first issues the required memory reads. It sits between the instruction decoder and the ALU/accumulator datapath; the memory and register file feed the ALU's `mem_out` and `reg_out` directly.

## Interface
- `DW`, default 8: data width (ALU operand, `immediate`, `mem_rdata`).
- `AW`, default 8: memory address width. It must satisfy `AW <= DW`, because a pointer is taken from `mem_rdata[AW-1:0]`.
- `RW`, default 3: register index width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ins_valid`  in  1  instruction present.
- `ins_ready`  out  1  controller can accept; transfer when `ins_valid & ins_ready` at a rising edge.
- `ins_op`  in  3  ALU op code; 0 = NOP, 1..7 passed to the ALU.
- `ins_src`  in  2  `data_src_t`: `SRC_MEM_ADDR`=0, `SRC_IMMEDIATE`=1, `SRC_INDIRECT`=2, `SRC_REG`=3.
- `ins_arg`  in  DW  operand field. Its meaning depends on `ins_src`: immediate value, memory address (low AW bits), pointer address (low AW bits), or register index (low RW bits).
- `ins_upd_cy`  in  1  carry flag update enable for this instruction.
- `mem_rd`  out  1  memory read strobe; `mem_rdata` is valid the cycle after the strobe.
- `mem_addr`  out  AW  memory read address.
- `mem_rdata`  in  DW  memory read data; the same bus feeds the ALU's `mem_out`.
- `data_src`  out  2  to ALU `data_src`.
- `op`  out  3  to ALU `op`.
- `immediate`  out  DW  to ALU `immediate`.
- `reg_sel`  out  RW  register file read index; the register file drives ALU `reg_out`.
- `ce_a`  out  1  accumulator enable strobe.
- `ce_cy`  out  1  carry flag enable strobe.
- `busy`  out  1  instruction in progress (state is not IDLE).
- `done`  out  1  one-cycle pulse in the execute cycle.

## Operation
- FSM states:
  - `IDLE`: `ins_ready`=1. On accept, latch op, src, arg and upd_cy into registers that drive `op`, `data_src`, `immediate` (=arg), `reg_sel` (=arg[RW-1:0]) and the internal address register (=arg[AW-1:0]).
    - Next state: `SRC_IMMEDIATE` or `SRC_REG` → `EXEC`; `SRC_MEM_ADDR` → `RD`; `SRC_INDIRECT` → `PTR`.
  - `PTR`: `mem_rd`=1, `mem_addr`=latched address. Next state `LDPTR`.
  - `LDPTR`: capture `mem_rdata[AW-1:0]` into the address register. Next state `RD`.
  - `RD`: `mem_rd`=1, `mem_addr`=address register. Next state `EXEC`.
  - `EXEC`: assert `done`=1, `ce_a`=(op≠0) and `ce_cy`=(op≠0)&upd_cy. `mem_rdata` from `RD` is valid in this cycle. Next state `IDLE`.
- `ins_ready` is high only in `IDLE`, and low while `rst` is low.
- `ins_valid` is never dropped by the controller. A request presented while busy waits until `IDLE`.
- `data_src`, `op`, `immediate` and `reg_sel` hold their latched values from acceptance until the next acceptance. They are stable throughout `EXEC`.
- `mem_addr` is 0 whenever `mem_rd`=0.
- `ce_a`, `ce_cy`, `mem_rd` and `done` are decoded from state only. They never assert outside the states listed above.
- Each instruction produces exactly one `done` pulse and at most one `ce_a` pulse.
- Memory reads per instruction: 0 for `SRC_IMMEDIATE` and `SRC_REG`, 1 for `SRC_MEM_ADDR`, 2 for `SRC_INDIRECT`.

## Timing
- Reset (`rst` low):
  - state = `IDLE`.
  - `ins_ready`=0.
  - `busy`, `done`, `ce_a`, `ce_cy` and `mem_rd` are all 0.
  - `mem_addr`=0, `data_src`=`SRC_MEM_ADDR` (0), `op`=0, `immediate`=0, `reg_sel`=0.
- Reset mid-instruction: outputs go to their reset values asynchronously and the instruction is discarded. No `ce_a` or `done` is produced for it. After `rst` rises, `ins_ready`=1 on the first cycle.
- For an instruction accepted at edge T, the `EXEC` cycle falls as follows:
  - `SRC_IMMEDIATE` / `SRC_REG`: cycle T+1.
  - `SRC_MEM_ADDR`: `RD` in T+1, `EXEC` in T+2.
  - `SRC_INDIRECT`: `PTR` in T+1, `LDPTR` in T+2, `RD` in T+3, `EXEC` in T+4.
- The ALU captures the accumulator and flags at the edge closing `EXEC`.
- Minimum issue interval is 2 cycles (`EXEC` → `IDLE` → accept).
- `busy` is 1 from the cycle after acceptance through `EXEC`.

## Test plan
- Reset: assert `rst`=0 for 12 ns mid-run → every output at its reset value. After release, `ins_ready`=1, then accept op=1, `SRC_IMMEDIATE`, arg=8'h3C.
- Immediate: op=3'd1, src=1, arg=8'h3C, upd_cy=1 accepted at T → in T+1, `data_src`=1, `immediate`=8'h3C, `op`=1, and `ce_a`=`ce_cy`=`done`=1 for exactly one cycle; `mem_rd` never asserts.
- Memory address: op=3'd2, src=0, arg=8'h40, mem[0x40]=8'h5A → `mem_rd`=1 with `mem_addr`=8'h40 in T+1; `ce_a`=1 in T+2 with `mem_rdata`=8'h5A.
- Indirect: src=2, arg=8'h10, mem[0x10]=8'h80, mem[0x80]=8'hA5 → reads at 0x10 (T+1) and 0x80 (T+3), exactly two `mem_rd` pulses, `ce_a` in T+4.
- Strobe gating:
  - op=0 with `SRC_REG`, arg=3 → `done` pulses, `ce_a`=`ce_cy`=0, `reg_sel`=3.
  - op=5 with upd_cy=0 → `ce_a`=1, `ce_cy`=0.
- Reset at T+2 of an indirect instruction → no further `mem_rd`, no `ce_a`, no `done`. A back-to-back immediate stream with `ins_valid` held high afterwards is accepted every 2 cycles.
